rom_arbiter: RTL and testbench

- Shares one synchronous program ROM (8-bit address, registered 8-bit data, output gated by an enable) between two read requesters: port 0 is CPU fetch, port 1 is the debug/loader reader.
- After reset it reads ROM bytes 0..3 and checks them against the "ASRM" header. It reports the result, then arbitrates round-robin with one-cycle read latency and full pipelining.

---
 rtl/rom_arbiter.sv | 94 +++++++++
 tb/tb_rom_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: boots by checking the ROM header, then shares one registered ROM
// between two read ports with round-robin arbitration and one-cycle latency.
module rom_arbiter #(
    parameter int          ADDR_W       = 8,
    parameter logic [31:0] MAGIC        = 32'h4153524D,
    parameter bit          CHECK_HEADER = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    output logic              valid0,
    output logic [7:0]        rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack1,
    output logic              valid1,
    output logic [7:0]        rdata1,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_enable,
    input  logic [7:0]        rom_data,
    output logic              boot_done,
    output logic              header_ok
);
    typedef enum logic {BOOT, RUN} state_t;
    localparam state_t RST_STATE = CHECK_HEADER ? BOOT : RUN;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              mism_q, mism_d, ok_q, ok_d, lg_q, lg_d, en_q, en_d;
    logic [1:0]        pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        d0_q, d0_d, d1_q, d1_d, exp_byte;
    logic              boot, run, last_boot, g0, g1;

    // lg_q is the port granted last; the other port wins a conflict
    always_comb begin
        boot      = state_q == BOOT;
        run       = state_q == RUN;
        last_boot = boot && cnt_q == 3'd4;
        g0        = run & req0 & (~req1 | lg_q);
        g1        = run & req1 & (~req0 | ~lg_q);
        exp_byte  = 8'(MAGIC >> {3'd4 - cnt_q, 3'b000});
        state_d   = last_boot ? RUN : state_q;
        cnt_d     = (boot && !last_boot) ? cnt_q + 3'd1 : cnt_q;
        mism_d    = mism_q | (boot && cnt_q != 3'd0 && rom_data != exp_byte);
        ok_d      = last_boot ? ~mism_d : ok_q;
        lg_d      = g0 ? 1'b0 : g1 ? 1'b1 : lg_q;
        en_d      = boot ? (cnt_q < 3'd4) : (g0 | g1);
        pend_d    = {g1, g0};
        addr_d    = g0 ? addr0 : g1 ? addr1 : addr_q;
        d0_d      = pend_q[0] ? rom_data : d0_q;
        d1_d      = pend_q[1] ? rom_data : d1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            mism_q  <= 1'b0;
            ok_q    <= 1'b0;
            lg_q    <= 1'b1;
            en_q    <= 1'b0;
            pend_q  <= '0;
            addr_q  <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mism_q  <= mism_d;
            ok_q    <= ok_d;
            lg_q    <= lg_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
        end
    end

    // read data is the ROM output in the return cycle, otherwise the held byte
    assign ack0       = reset & g0;
    assign ack1       = reset & g1;
    assign valid0     = pend_q[0];
    assign valid1     = pend_q[1];
    assign rdata0     = d0_d;
    assign rdata1     = d1_d;
    assign rom_enable = en_q;
    assign rom_addr   = !reset ? '0 : boot ? ADDR_W'(cnt_q) : addr_d;
    assign boot_done  = reset & run;
    assign header_ok  = reset & (CHECK_HEADER ? ok_q : 1'b1);
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: vector table, hand-written boot/reset sequences and a random
// run against a request-level reference model of the arbiter.
module tb_rom_arbiter;
    logic       clk = 1'b0;
    logic       reset, req0, req1, ack0, ack1, valid0, valid1, rom_enable, boot_done, header_ok;
    logic [7:0] addr0, addr1, rdata0, rdata1, rom_addr, rom_data, rq;
    logic       reset_b, req0_b, req1_b, ack0_b, ack1_b, valid0_b, valid1_b, rom_enable_b;
    logic       boot_done_b, header_ok_b;
    logic [7:0] addr0_b, addr1_b, rdata0_b, rdata1_b, rom_addr_b, rom_data_b, rq_b;
    logic [7:0] rom [256];
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rq <= rom[rom_addr];
    always @(posedge clk) rq_b <= rom[rom_addr_b];
    assign rom_data   = rom_enable ? rq : 8'h00;
    assign rom_data_b = rom_enable_b ? rq_b : 8'h00;

    rom_arbiter #(.CHECK_HEADER(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .ack0(ack0), .valid0(valid0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .ack1(ack1), .valid1(valid1), .rdata1(rdata1),
        .rom_addr(rom_addr), .rom_enable(rom_enable), .rom_data(rom_data),
        .boot_done(boot_done), .header_ok(header_ok)
    );

    rom_arbiter #(.CHECK_HEADER(1'b0)) u_nohdr (
        .clk(clk), .reset(reset_b),
        .req0(req0_b), .addr0(addr0_b), .ack0(ack0_b), .valid0(valid0_b), .rdata0(rdata0_b),
        .req1(req1_b), .addr1(addr1_b), .ack1(ack1_b), .valid1(valid1_b), .rdata1(rdata1_b),
        .rom_addr(rom_addr_b), .rom_enable(rom_enable_b), .rom_data(rom_data_b),
        .boot_done(boot_done_b), .header_ok(header_ok_b)
    );

    typedef struct {
        logic       r0, r1;
        logic [7:0] a0, a1;
        logic       k0, k1, v0, v1, en;
        logic [7:0] d0, d1;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r0, input logic r1, input logic [7:0] a0, input logic [7:0] a1);
        req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
    endtask

    // releases reset in B0 and walks n boot cycles with both ports requesting
    task automatic boot_seq(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (k == 0) reset = 1'b1;
            set_in(1'b1, 1'b1, 8'h2B, 8'h2C);
            @(negedge clk);
            if (k < 4) chk("boot_addr", 32'(rom_addr), 32'(k));
            chk("boot_en", 32'(rom_enable), 32'(k >= 1 && k <= 4));
            chk("boot_no_ack", {ack0, ack1}, 0);
            chk("boot_done_early", {boot_done, header_ok}, 0);
        end
    endtask

    initial begin
        int   g, pg, lg, la;
        logic r0, r1;
        logic [7:0] a0, a1, pa, hd0, hd1;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;
        rom[0] = 8'h41; rom[1] = 8'h53; rom[2] = 8'h52; rom[3] = 8'h4D;
        rom[8'h04] = 8'h14; rom[8'h2A] = 8'h48; rom[8'h2B] = 8'h65; rom[8'h2C] = 8'h6C;
        rom[8'h30] = 8'h20; rom[8'h31] = 8'h77; rom[8'h32] = 8'h6F; rom[8'hFF] = 8'h00;
        tbl[0]  = '{1'b1, 1'b1, 8'h2B, 8'h2C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 8'h2B, 8'h2C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h65, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 8'h2B, 8'h2C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h65, 8'h6C};
        tbl[3]  = '{1'b1, 1'b1, 8'h2B, 8'h2C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h65, 8'h6C};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 8'h30, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h65, 8'h6C};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, 8'h31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h65, 8'h20};
        tbl[6]  = '{1'b0, 1'b1, 8'h00, 8'h32, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h65, 8'h77};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h65, 8'h6F};
        tbl[8]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h65, 8'h6F};
        tbl[9]  = '{1'b1, 1'b1, 8'h2A, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h6F};
        tbl[10] = '{1'b1, 1'b1, 8'h2A, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h14};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h48, 8'h14};

        reset = 1'b0; reset_b = 1'b0;
        set_in(1'b1, 1'b1, 8'h2B, 8'h2C);
        req0_b = 1'b1; req1_b = 1'b0; addr0_b = 8'h04; addr1_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {valid0, valid1, rdata0, rdata1, rom_enable, boot_done, header_ok,
                              ack0, ack1, rom_addr}, 0);
        chk("reset_outputs_nohdr", {ack0_b, valid0_b, boot_done_b, header_ok_b, rom_addr_b}, 0);

        boot_seq(5);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            set_in(tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].a1);
            @(negedge clk);
            if (i == 0) chk("b5_done_ok", {boot_done, header_ok}, 2'b11);
            chk($sformatf("vec%0d_ack", i), {ack0, ack1}, {tbl[i].k0, tbl[i].k1});
            chk($sformatf("vec%0d_valid", i), {valid0, valid1, rom_enable}, {tbl[i].v0, tbl[i].v1, tbl[i].en});
            chk($sformatf("vec%0d_rdata", i), {rdata0, rdata1}, {tbl[i].d0, tbl[i].d1});
        end

        // corrupt header byte 2: boot completes but header_ok stays low
        rom[2] = 8'h00;
        @(posedge clk); #1; reset = 1'b0;
        boot_seq(5);
        @(posedge clk); #1; set_in(1'b1, 1'b0, 8'h2A, 8'h00);
        @(negedge clk);
        chk("bad_hdr_done_ok", {boot_done, header_ok}, 2'b10);
        chk("bad_hdr_ack0", {ack0, ack1}, 2'b10);
        @(posedge clk); #1; set_in(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("bad_hdr_read", {valid0, valid1, rdata0}, {2'b10, 8'h48});
        rom[2] = 8'h52;

        // reset right after a grant: the accepted read never shows valid
        @(posedge clk); #1; set_in(1'b1, 1'b0, 8'h31, 8'h00);
        @(negedge clk);
        chk("pre_rst_ack0", 32'(ack0), 1);
        @(posedge clk); #1; reset = 1'b0; set_in(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("rst_discard", {valid0, rdata0, rom_enable}, 0);

        // reset mid-boot in B2, then a clean restart from address 0
        boot_seq(2);
        @(posedge clk); #1; reset = 1'b0;
        #1;
        chk("midboot_rst", {valid0, valid1, rdata0, rdata1, rom_enable, boot_done, header_ok,
                            ack0, ack1, rom_addr}, 0);
        repeat (2) @(posedge clk);
        boot_seq(5);
        @(posedge clk); #1; set_in(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("restart_done_ok", {boot_done, header_ok}, 2'b11);

        // random traffic against a request-level model
        lg = 1; pg = -1; la = -1; pa = 8'h00; hd0 = 8'h00; hd1 = 8'h00;
        for (int c = 0; c < 400; c++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            a0 = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
            a1 = 8'($urandom);
            @(posedge clk); #1; set_in(r0, r1, a0, a1);
            @(negedge clk);
            if (r0 && r1) g = 1 - lg;
            else if (r0) g = 0;
            else if (r1) g = 1;
            else g = -1;
            if (pg == 0) hd0 = rom[pa];
            if (pg == 1) hd1 = rom[pa];
            chk("rnd_ack", {ack0, ack1}, {g == 0, g == 1});
            chk("rnd_valid", {valid0, valid1, rom_enable}, {pg == 0, pg == 1, pg >= 0});
            chk("rnd_rdata", {rdata0, rdata1}, {hd0, hd1});
            if (g >= 0) chk("rnd_addr", 32'(rom_addr), 32'(g == 0 ? a0 : a1));
            else if (la >= 0) chk("rnd_addr_hold", 32'(rom_addr), 32'(la));
            if (g >= 0) begin
                lg = g;
                pa = (g == 0) ? a0 : a1;
                la = int'(pa);
            end
            pg = g;
        end

        // CHECK_HEADER=0: serving starts in the first cycle after release
        @(posedge clk); #1; reset_b = 1'b1;
        @(negedge clk);
        chk("nohdr_first", {ack0_b, ack1_b, boot_done_b, header_ok_b}, 4'b1011);
        chk("nohdr_addr", 32'(rom_addr_b), 32'h04);
        @(posedge clk); #1; req0_b = 1'b0;
        @(negedge clk);
        chk("nohdr_read", {valid0_b, valid1_b, rdata0_b, header_ok_b}, {2'b10, 8'h14, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
